rf_wb_scheduler: RTL

Write-port scheduler and hazard scoreboard for the 32x32 register file (single write port, two combinational read ports). It arbitrates the ALU and load-unit writeback streams onto the one RF write port through a registered write stage and tracks per-register pending-write busy bits so the issue stage stalls on RAW/WAW hazards. Sits between the execute units and the RF, alongside the issue logic.

---
 rtl/rf_wb_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/load writebacks onto one
// registered write port and keeps a pending-write scoreboard for issue hazards.
module rf_wb_scheduler #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd_addr,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd_addr,
  input  logic [XLEN-1:0] i_ld_data,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_rd_addr,
  output logic [XLEN-1:0] o_rf_rd,
  input  logic            i_iss_valid,
  input  logic            i_iss_has_rd,
  input  logic [4:0]      i_iss_rd_addr,
  input  logic [4:0]      i_iss_rs1_addr,
  input  logic [4:0]      i_iss_rs2_addr,
  output logic            o_iss_stall,
  output logic            o_wb_unexp
);

  logic [3:0]      r_starve_cnt;
  logic            r_we;
  logic [4:0]      r_wr_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [31:1]     r_busy;

  logic [31:0]     w_busy;
  logic [31:0]     w_busy_next;
  logic            w_starved;
  logic            w_alu_win;
  logic            w_ld_win;
  logic            w_set;
  logic            w_clr;

  assign w_busy    = {r_busy, 1'b0};
  assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

  // Load has priority except when the ALU has lost STARVE_MAX times in a row.
  assign w_alu_win = i_alu_valid && (!i_ld_valid || w_starved);
  assign w_ld_win  = i_ld_valid && !w_alu_win;

  assign o_alu_ready = i_rst_n && w_alu_win;
  assign o_ld_ready  = i_rst_n && w_ld_win;

  assign o_iss_stall = !i_rst_n ||
                       (i_iss_valid && (w_busy[i_iss_rs1_addr] || w_busy[i_iss_rs2_addr] ||
                                        (i_iss_has_rd && w_busy[i_iss_rd_addr])));

  assign w_set = i_iss_valid && !o_iss_stall && i_iss_has_rd && (i_iss_rd_addr != 5'd0);
  assign w_clr = r_we;

  assign o_rf_we      = r_we;
  assign o_rf_rd_addr = r_wr_addr;
  assign o_rf_rd      = r_wr_data;
  assign o_wb_unexp   = r_we && !w_busy[r_wr_addr];

  // Per-register next state; a set from issue overrides a same-edge clear.
  assign w_busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign w_busy_next[gi] = (w_set && (i_iss_rd_addr == 5'(gi))) ? 1'b1 :
                               (w_clr && (r_wr_addr == 5'(gi)))     ? 1'b0 :
                               w_busy[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next[31:1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (i_alu_valid && !o_alu_ready) begin
      if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // x0 writes are accepted but never reach the RF.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we      <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= '0;
    end else if (o_alu_ready) begin
      r_we      <= (i_alu_rd_addr != 5'd0);
      r_wr_addr <= i_alu_rd_addr;
      r_wr_data <= i_alu_data;
    end else if (o_ld_ready) begin
      r_we      <= (i_ld_rd_addr != 5'd0);
      r_wr_addr <= i_ld_rd_addr;
      r_wr_data <= i_ld_data;
    end else begin
      r_we      <= 1'b0;
    end
  end

endmodule
